// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO-to-peripheral bridge.
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    HOLD    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam int unsigned UART_STAT_OFFSET = 4;
  localparam logic [31:0] ERR_PATTERN      = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_decode.sv
// Combinational address decoder for the UART data/status registers.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   UART_BASE = 32'hFFFF_FF00
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_data,
  output logic              hit_stat,
  output logic              unmapped
);

  localparam logic [ADDR_W-1:0] STAT_ADDR = UART_BASE + ADDR_W'(UART_STAT_OFFSET);

  assign hit_data = (addr == UART_BASE);
  assign hit_stat = (addr == STAT_ADDR);
  assign unmapped = ~(hit_data | hit_stat);

endmodule

// File: rtl/mmio_bridge.sv
// CPU MMIO to peripheral strobe bridge with programmable strobe hold time.
// Optional sticky unmapped-access error and read pattern under MMIO_ERR_EN.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] UART_BASE   = 32'hFFFF_FF00,
  parameter int unsigned       HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              per_rd,
  output logic              per_wr,
  output logic              per_s_io,
  output logic              per_s_mmio,
  output logic [7:0]        per_wdata,
  input  logic [7:0]        per_rdata,
  output logic              err
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef MMIO_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = ERR_PATTERN;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             sel_io_q, sel_io_d;
  logic [7:0]       wdata_d;
  logic [31:0]      rdata_d;
  logic             hit_data, hit_stat, unmapped;
  logic             active_d;
  logic             per_rd_d, per_wr_d, per_s_io_d, per_s_mmio_d, cpu_ready_d;
  logic             unused_wdata_c;

  assign unused_wdata_c = ^cpu_wdata[31:8];

  mmio_decode #(
    .ADDR_W    (ADDR_W),
    .UART_BASE (UART_BASE)
  ) u_decode (
    .addr     (cpu_addr),
    .hit_data (hit_data),
    .hit_stat (hit_stat),
    .unmapped (unmapped)
  );

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    sel_io_d = sel_io_q;
    wdata_d  = per_wdata;
    rdata_d  = cpu_rdata;

    case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          is_wr_d = cpu_wr;
          cnt_d   = '0;
          if (unmapped) begin
            state_d = DONE;
            if (!cpu_wr) rdata_d = UNMAPPED_RDATA;
          end else begin
            state_d  = SETUP;
            sel_io_d = hit_data & ~hit_stat;
            wdata_d  = cpu_wdata[7:0];
          end
        end
      end
      SETUP: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d = {24'h0, per_rdata};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = RELEASE;
      // Wait for the CPU to drop its level request so it is not replayed
      RELEASE: if (!cpu_rd && !cpu_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active_d     = (state_d == SETUP) || (state_d == HOLD);
    per_s_mmio_d = active_d;
    per_s_io_d   = active_d & sel_io_d;
    per_rd_d     = (state_d == HOLD) & ~is_wr_d;
    per_wr_d     = (state_d == HOLD) & is_wr_d;
    cpu_ready_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      sel_io_q   <= 1'b0;
      per_wdata  <= 8'h0;
      cpu_rdata  <= 32'h0;
      per_rd     <= 1'b0;
      per_wr     <= 1'b0;
      per_s_io   <= 1'b0;
      per_s_mmio <= 1'b0;
      cpu_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      sel_io_q   <= sel_io_d;
      per_wdata  <= wdata_d;
      cpu_rdata  <= rdata_d;
      per_rd     <= per_rd_d;
      per_wr     <= per_wr_d;
      per_s_io   <= per_s_io_d;
      per_s_mmio <= per_s_mmio_d;
      cpu_ready  <= cpu_ready_d;
    end
  end

`ifdef MMIO_ERR_EN
  // Sticky flag: any unmapped access accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if ((state_q == IDLE) && (cpu_rd || cpu_wr) && unmapped) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed table, reset-mid-access and random accesses.
module tb_mmio_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int          HOLD = 16;
  localparam int          MLAT = HOLD + 2;

`ifdef MMIO_ERR_EN
  localparam logic [31:0] UNM_RD = 32'hDEAD_BEEF;
  localparam logic        ERR_ON = 1'b1;
`else
  localparam logic [31:0] UNM_RD = 32'h0;
  localparam logic        ERR_ON = 1'b0;
`endif

  logic        clk, rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, per_rd, per_wr, per_s_io, per_s_mmio, err;
  logic [7:0]  per_wdata, per_rdata;

  int compared;
  int mismatched;

  logic [31:0] m_rdata;
  logic        m_err;

  mmio_bridge #(
    .ADDR_W      (32),
    .UART_BASE   (BASE),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .per_rd     (per_rd),
    .per_wr     (per_wr),
    .per_s_io   (per_s_io),
    .per_s_mmio (per_s_mmio),
    .per_wdata  (per_wdata),
    .per_rdata  (per_rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  prd;
    int          extra;
    int          lat;
    int          rdc;
    int          wrc;
    logic        io;
    logic [31:0] rdata;
    logic        errv;
  } vec_t;

  typedef struct {
    int          lat;
    int          rdc;
    int          wrc;
    int          smc;
    int          rdy;
    logic        io;
    logic [7:0]  wd;
    logic [31:0] rdata;
  } obs_t;

  vec_t tbl[8];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] prd, input int extra,
                              input int lat, input int rdc, input int wrc, input logic io,
                              input logic [31:0] rdata, input logic errv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.prd = prd; v.extra = extra;
    v.lat = lat; v.rdc = rdc; v.wrc = wrc; v.io = io; v.rdata = rdata; v.errv = errv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Drive one level-held access, observe every cycle of it, then drop the request
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] prd, input int extra,
                        output obs_t o);
    o.lat = -1; o.rdc = 0; o.wrc = 0; o.smc = 0; o.rdy = 0;
    o.io = 1'b0; o.wd = 8'h0; o.rdata = 32'h0;
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; per_rdata = prd;
    @(posedge clk);
    #1;
    cpu_addr  = ~addr;
    cpu_wdata = ~wdata;
    for (int n = 1; n <= MLAT + extra; n++) begin
      @(negedge clk);
      if (per_rd) o.rdc++;
      if (per_wr) o.wrc++;
      if (per_s_mmio) o.smc++;
      if (per_rd || per_wr) begin
        o.io = per_s_io;
        o.wd = per_wdata;
      end
      if (cpu_ready) begin
        o.rdy++;
        if (o.lat < 0) begin
          o.lat   = n;
          o.rdata = cpu_rdata;
        end
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compare_obs(input string tag, input obs_t o, input int lat, input int rdc,
                             input int wrc, input logic io, input logic [7:0] wd,
                             input logic [31:0] rdata, input logic errv);
    int strobes;
    strobes = rdc + wrc;
    check({tag, "_latency"}, 32'(o.lat), 32'(lat));
    check({tag, "_ready_pulses"}, 32'(o.rdy), 32'd1);
    check({tag, "_per_rd_cycles"}, 32'(o.rdc), 32'(rdc));
    check({tag, "_per_wr_cycles"}, 32'(o.wrc), 32'(wrc));
    check({tag, "_sel_cycles"}, 32'(o.smc), (strobes > 0) ? 32'(HOLD + 1) : 32'd0);
    check({tag, "_rdata"}, o.rdata, rdata);
    check({tag, "_err"}, 32'(err), 32'(errv));
    if (strobes > 0) check({tag, "_s_io"}, 32'(o.io), 32'(io));
    if (wrc > 0) check({tag, "_per_wdata"}, 32'(o.wd), 32'(wd));
  endtask

  // Reference: mapped accesses take SETUP+HOLD+DONE, unmapped ones complete at once
  task automatic model_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [7:0] prd, input int extra);
    logic mapped;
    int   lat, rdc, wrc;
    obs_t o;
    mapped = (addr == BASE) || (addr == BASE + 32'd4);
    lat    = mapped ? MLAT : 1;
    rdc    = (mapped && !wr) ? HOLD : 0;
    wrc    = (mapped && wr) ? HOLD : 0;
    if (!wr) m_rdata = mapped ? {24'h0, prd} : UNM_RD;
    if (!mapped) m_err = m_err | ERR_ON;
    access(rd, wr, addr, wdata, prd, extra, o);
    compare_obs(tag, o, lat, rdc, wrc, addr == BASE, wdata[7:0], m_rdata, m_err);
  endtask

  initial begin
    obs_t o;
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; per_rdata = 8'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({cpu_ready, per_rd, per_wr, per_s_io, per_s_mmio, err}), 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_wdata", 32'(per_wdata), 32'h0);
    rst = 1'b1;

    tbl[0] = mk(1'b0, 1'b1, BASE,         32'h0000_0041, 8'h00, 0,   MLAT, 0,    HOLD, 1'b1, 32'h0,  1'b0);
    tbl[1] = mk(1'b1, 1'b0, BASE + 32'd4, 32'h0,         8'h02, 0,   MLAT, HOLD, 0,    1'b0, 32'h2,  1'b0);
    tbl[2] = mk(1'b1, 1'b0, BASE,         32'h0,         8'h5A, 100, MLAT, HOLD, 0,    1'b1, 32'h5A, 1'b0);
    tbl[3] = mk(1'b1, 1'b1, BASE,         32'hFFFF_FF77, 8'h33, 0,   MLAT, 0,    HOLD, 1'b1, 32'h5A, 1'b0);
    tbl[4] = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,        8'h99, 0,   1,    0,    0,    1'b0, UNM_RD, ERR_ON);
    tbl[5] = mk(1'b0, 1'b1, 32'h0000_0100, 32'h12,       8'h00, 0,   1,    0,    0,    1'b0, UNM_RD, ERR_ON);
    tbl[6] = mk(1'b1, 1'b0, BASE + 32'd8, 32'h0,         8'hFF, 0,   1,    0,    0,    1'b0, UNM_RD, ERR_ON);
    tbl[7] = mk(1'b1, 1'b0, BASE,         32'h0,         8'h80, 0,   MLAT, HOLD, 0,    1'b1, 32'h80, ERR_ON);

    for (int i = 0; i < 8; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].prd, tbl[i].extra, o);
      compare_obs($sformatf("vec%0d", i), o, tbl[i].lat, tbl[i].rdc, tbl[i].wrc,
                  tbl[i].io, tbl[i].wdata[7:0], tbl[i].rdata, tbl[i].errv);
    end

    // Reset asserted during the 5th HOLD cycle of a write
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = BASE; cpu_wdata = 32'h55;
    @(posedge clk);
    repeat (6) @(negedge clk);
    check("midrst_wr_before", 32'(per_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_ctrl_after", 32'({cpu_ready, per_rd, per_wr, per_s_io, per_s_mmio}), 32'h0);
    check("midrst_err_after", 32'(err), 32'h0);
    cpu_wr = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("midrst_no_ready", 32'({cpu_ready, per_wr, per_s_mmio}), 32'h0);
    end
    rst = 1'b1;
    m_rdata = 32'h0;
    m_err   = 1'b0;
    model_access("post_rst_wr", 1'b0, 1'b1, BASE, 32'hA5, 8'h00, 0);
    model_access("post_rst_rd", 1'b1, 1'b0, BASE + 32'd4, 32'h0, 8'hC3, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] addr;
      logic [1:0]  k;
      int          sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       addr = BASE;
        1:       addr = BASE + 32'd4;
        2:       addr = BASE + 32'd8;
        default: addr = $urandom;
      endcase
      k = 2'($urandom_range(1, 3));
      model_access($sformatf("rnd%0d", i), k[0], k[1], addr, $urandom,
                   8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
